// File: rtl/hazard_controller_pkg.sv
// ============================================================================
// Module   : hazard_controller_pkg
// Brief    : Shared state encodings, address width and NOP encoding for the
//            hazard controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_controller_pkg;

  localparam int HC_AWIDTH = 5;

  typedef enum logic [1:0] {
    HC_RUN        = 2'd0,
    HC_LOAD_STALL = 2'd1,
    HC_FLUSH      = 2'd2,
    HC_MEM_WAIT   = 2'd3
  } hc_state_e;

  // Control word injected into ID/EX as a bubble: every control line low.
  localparam logic [7:0] HC_NOP_CTRL = 8'h00;

endpackage

`default_nettype wire

// File: rtl/hc_sat_counter.sv
// ============================================================================
// Module   : hc_sat_counter
// Brief    : Up-counter with increment enable that sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             hc_clk,
  input  logic             hc_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module   : hazard_controller
// Brief    : Stall/bubble/flush sequencer for the five-stage MIPS pipeline
//            with saturating stall and redirect counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int AWIDTH            = HC_AWIDTH,
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 2,
  parameter int MEM_TIMEOUT       = 16,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic                 hc_i_ce,
  input  logic [AWIDTH-1:0]    hc_i_id_rs,
  input  logic [AWIDTH-1:0]    hc_i_id_rt,
  input  logic                 hc_i_id_use_rs,
  input  logic                 hc_i_id_use_rt,
  input  logic [AWIDTH-1:0]    hc_i_ex_rd,
  input  logic                 hc_i_ex_memread,
  input  logic                 hc_i_change_pc,
  input  logic                 hc_i_mem_req,
  input  logic                 hc_i_mem_ready,
  output logic                 hc_o_stall_if,
  output logic                 hc_o_stall_id,
  output logic                 hc_o_stall_ex,
  output logic                 hc_o_bubble_ex,
  output logic                 hc_o_flush_id,
  output logic                 hc_o_flush_ex,
  output logic [1:0]           hc_o_state,
  output logic                 hc_o_timeout,
  output logic [CNT_WIDTH-1:0] hc_o_stall_cnt,
  output logic [CNT_WIDTH-1:0] hc_o_flush_cnt
);

  localparam int c_rem_max = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int c_rem_w   = $clog2(c_rem_max + 1);
  localparam int c_wait_w  = $clog2(MEM_TIMEOUT + 1);

  localparam logic [c_rem_w-1:0]  c_load_rem  = c_rem_w'(LOAD_STALL_CYCLES - 1);
  localparam logic [c_rem_w-1:0]  c_flush_rem = c_rem_w'(FLUSH_CYCLES - 1);
  localparam logic [c_wait_w-1:0] c_wait_max  = c_wait_w'(MEM_TIMEOUT);

  hc_state_e           r_state, w_state_nxt;
  logic [c_rem_w-1:0]  r_rem, w_rem_nxt;
  logic [c_wait_w-1:0] r_wait, w_wait_nxt;
  logic                r_timeout;

  logic w_luh, w_memstall;
  logic w_stall_all, w_load_stall, w_flush, w_redirect, w_flush_inc, w_timeout_set;

  assign w_memstall = hc_i_mem_req && !hc_i_mem_ready;
  assign w_luh      = hc_i_ex_memread && (hc_i_ex_rd != '0) &&
                      ((hc_i_id_use_rs && (hc_i_id_rs == hc_i_ex_rd)) ||
                       (hc_i_id_use_rt && (hc_i_id_rt == hc_i_ex_rd)));

  always_ff @(posedge hc_clk or negedge hc_rst) begin
    if (!hc_rst) begin
      r_state   <= HC_RUN;
      r_rem     <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_wait    <= w_wait_nxt;
      r_timeout <= r_timeout | w_timeout_set;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_wait_nxt    = r_wait;
    w_stall_all   = 1'b0;
    w_load_stall  = 1'b0;
    w_flush       = 1'b0;
    w_redirect    = 1'b0;
    w_flush_inc   = 1'b0;
    w_timeout_set = 1'b0;
    if (hc_i_ce) begin
      case (r_state)
        HC_RUN, HC_LOAD_STALL: begin
          if (w_memstall) begin
            w_stall_all = 1'b1;
            w_state_nxt = HC_MEM_WAIT;
            w_wait_nxt  = c_wait_w'(1);
          end else if (hc_i_change_pc) begin
            w_redirect = 1'b1;
          end else if (r_state == HC_LOAD_STALL) begin
            w_load_stall = 1'b1;
            w_rem_nxt    = r_rem - c_rem_w'(1);
            w_state_nxt  = (w_rem_nxt == '0) ? HC_RUN : HC_LOAD_STALL;
          end else if (w_luh) begin
            w_load_stall = 1'b1;
            w_rem_nxt    = c_load_rem;
            w_state_nxt  = (LOAD_STALL_CYCLES > 1) ? HC_LOAD_STALL : HC_RUN;
          end
        end
        HC_FLUSH: begin
          w_flush = 1'b1;
          if (hc_i_change_pc) begin
            w_redirect = 1'b1;
          end else begin
            w_rem_nxt   = r_rem - c_rem_w'(1);
            w_state_nxt = (w_rem_nxt == '0) ? HC_RUN : HC_FLUSH;
          end
        end
        HC_MEM_WAIT: begin
          // Ready wins over timeout; a redirect is only honoured on completion.
          if (hc_i_mem_ready) begin
            if (hc_i_change_pc) w_redirect = 1'b1;
            else                w_state_nxt = HC_RUN;
          end else if (r_wait == c_wait_max) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = HC_RUN;
          end else begin
            w_stall_all = 1'b1;
            w_wait_nxt  = r_wait + c_wait_w'(1);
          end
        end
        default: w_state_nxt = HC_RUN;
      endcase
      if (w_redirect) begin
        w_flush     = 1'b1;
        w_flush_inc = 1'b1;
        w_rem_nxt   = c_flush_rem;
        w_state_nxt = (FLUSH_CYCLES > 1) ? HC_FLUSH : HC_RUN;
      end
    end
  end

  assign hc_o_stall_if  = w_stall_all | w_load_stall;
  assign hc_o_stall_id  = w_stall_all | w_load_stall;
  assign hc_o_stall_ex  = w_stall_all;
  assign hc_o_bubble_ex = w_load_stall;
  assign hc_o_flush_id  = w_flush;
  assign hc_o_flush_ex  = w_flush;
  assign hc_o_state     = r_state;
  assign hc_o_timeout   = r_timeout;

  hc_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .hc_clk  (hc_clk),
    .hc_rst  (hc_rst),
    .i_inc   (hc_o_stall_if),
    .o_count (hc_o_stall_cnt)
  );

  hc_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .hc_clk  (hc_clk),
    .hc_rst  (hc_rst),
    .i_inc   (w_flush_inc),
    .o_count (hc_o_flush_cnt)
  );

endmodule

`default_nettype wire
